// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the fft_step butterfly stage.
// Arithmetic runs on sign-extended 64-bit halves and is narrowed once it has been saturated.
package fft_pkg;

  localparam int unsigned CPLX_W = 64;
  localparam int unsigned LOG2N  = 2;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {WOne, WNegJ, WGen} wclass_t;

  // W_N^k in Q1.(halfw-1), rounded to nearest; +1.0 clamps to the largest positive code
  function automatic cplx_t twiddle(input int unsigned k, input int unsigned n,
                                    input int unsigned halfw);
    real   ang;
    real   scale;
    real   c;
    real   s;
    cplx_t w;
    scale = 1.0;
    for (int unsigned b = 1; b < halfw; b++) scale = scale * 2.0;
    ang = 6.283185307179586 * $itor(k) / $itor(n);
    c   = $cos(ang) * scale;
    s   = -$sin(ang) * scale;
    if (c > scale - 1.0) c = scale - 1.0;
    if (s > scale - 1.0) s = scale - 1.0;
    w.re = longint'(c);
    w.im = longint'(s);
    return w;
  endfunction

  function automatic logic signed [CPLX_W-1:0] rnd_mul(input logic signed [CPLX_W-1:0] a,
                                                       input logic signed [CPLX_W-1:0] w,
                                                       input int unsigned halfw);
    logic signed [CPLX_W-1:0] bias;
    logic signed [CPLX_W-1:0] prod;
    bias = 64'sd1 <<< (halfw - 2);
    prod = a * w + bias;
    return prod >>> (halfw - 1);
  endfunction

  function automatic logic signed [CPLX_W-1:0] sat_add(input logic signed [CPLX_W-1:0] a,
                                                       input logic signed [CPLX_W-1:0] b,
                                                       input int unsigned halfw);
    logic signed [CPLX_W-1:0] max_v;
    logic signed [CPLX_W-1:0] min_v;
    logic signed [CPLX_W-1:0] sum;
    max_v = (64'sd1 <<< (halfw - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    sum   = a + b;
    if (sum > max_v) sum = max_v;
    if (sum < min_v) sum = min_v;
    return sum;
  endfunction

  // Butterfly p of stage s: top index i, bottom index j, twiddle exponent k
  function automatic void pair_of(input int unsigned p, input int unsigned s,
                                  input int unsigned n, output int unsigned i,
                                  output int unsigned j, output int unsigned k);
    int unsigned half;
    half = 1 << s;
    i    = (p / half) * 2 * half + (p % half);
    j    = i + half;
    k    = (p % half) * (n / (2 * half));
  endfunction

  function automatic wclass_t wclass_of(input int unsigned k, input int unsigned n);
    if (k == 0) return WOne;
    if (4 * k == n) return WNegJ;
    return WGen;
  endfunction

endpackage

// File: rtl/fft_step_if.sv
// Frame-in / spectrum-out bundle for fft_step; master drives frames, slave is the stage.
interface fft_step_if #(
  parameter int unsigned SAMPLES = 4,
  parameter int unsigned WIDTH   = 32
);
  localparam int unsigned LOG2_SAMPLES = $clog2(SAMPLES);
  localparam int unsigned SW = (LOG2_SAMPLES > 1) ? $clog2(LOG2_SAMPLES) : 1;

  logic             in_valid;
  logic [WIDTH-1:0] sampleInputs [SAMPLES-1:0];
  logic [SW-1:0]    stage_number;
  logic             out_valid;
  logic [WIDTH-1:0] display_stream1_1 [SAMPLES-1:0];

  modport master (
    output in_valid, sampleInputs, stage_number,
    input  out_valid, display_stream1_1
  );

  modport slave (
    input  in_valid, sampleInputs, stage_number,
    output out_valid, display_stream1_1
  );
endinterface

// File: rtl/fft_butterfly.sv
// One radix-2 butterfly: (a + W*b, a - W*b) with per-half saturation.
// W = 1 and W = -j skip the multiplier and are formed exactly.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned HALF_W = 16
) (
  input  cplx_t                 a_i,
  input  cplx_t                 b_i,
  input  cplx_t                 w_i,
  input  wclass_t               wclass_i,
  output logic [2*HALF_W-1:0]   sum_o,
  output logic [2*HALF_W-1:0]   diff_o
);

  cplx_t wb;

  always_comb begin
    wb = b_i;
    case (wclass_i)
      WOne: wb = b_i;
      WNegJ: begin
        wb.re = b_i.im;
        wb.im = -b_i.re;
      end
      default: begin
        wb.re = rnd_mul(b_i.re, w_i.re, HALF_W) - rnd_mul(b_i.im, w_i.im, HALF_W);
        wb.im = rnd_mul(b_i.re, w_i.im, HALF_W) + rnd_mul(b_i.im, w_i.re, HALF_W);
      end
    endcase
  end

  always_comb begin
    sum_o  = {HALF_W'(sat_add(a_i.im, wb.im, HALF_W)), HALF_W'(sat_add(a_i.re, wb.re, HALF_W))};
    diff_o = {HALF_W'(sat_add(a_i.im, -wb.im, HALF_W)),
              HALF_W'(sat_add(a_i.re, -wb.re, HALF_W))};
  end

endmodule

// File: rtl/fft_step.sv
// Registered radix-2 DIT butterfly stage over a full SAMPLES-word frame.
// Define FFT_STEP_RUNTIME_STAGE_EN to pick the stage from stage_number instead of STAGE.
module fft_step
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLES = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned STAGE   = 0
) (
  input  logic     clk,
  input  logic     rst,
  fft_step_if.slave bus
);

  localparam int unsigned HW           = WIDTH / 2;
  localparam int unsigned LOG2_SAMPLES = $clog2(SAMPLES);
  localparam int unsigned PAIRS        = SAMPLES / 2;
  localparam int unsigned IW           = LOG2_SAMPLES;
  localparam int unsigned PW           = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int unsigned SW           = (LOG2_SAMPLES > 1) ? $clog2(LOG2_SAMPLES) : 1;
  localparam int unsigned STAGE_MAX    = LOG2_SAMPLES - 1;

  cplx_t            x      [SAMPLES-1:0];
  cplx_t            tw     [SAMPLES-1:0];
  cplx_t            a_sel  [PAIRS-1:0];
  cplx_t            b_sel  [PAIRS-1:0];
  cplx_t            w_sel  [PAIRS-1:0];
  wclass_t          wc_sel [PAIRS-1:0];
  logic [WIDTH-1:0] bf_sum [PAIRS-1:0];
  logic [WIDTH-1:0] bf_diff[PAIRS-1:0];
  logic [WIDTH-1:0] out_d  [SAMPLES-1:0];
  logic [WIDTH-1:0] out_q  [SAMPLES-1:0];
  logic             valid_d, valid_q;
  logic [SW-1:0]    stage_sel;

  for (genvar n = 0; n < SAMPLES; n++) begin : g_in
    localparam cplx_t TwC = twiddle(n, SAMPLES, HW);
    assign tw[n] = TwC;
    assign x[n]  = '{re: CPLX_W'($signed(bus.sampleInputs[n][HW-1:0])),
                     im: CPLX_W'($signed(bus.sampleInputs[n][WIDTH-1:HW]))};
  end

`ifdef FFT_STEP_RUNTIME_STAGE_EN
  always_comb begin
    if (32'(bus.stage_number) > STAGE_MAX) stage_sel = SW'(STAGE_MAX);
    else stage_sel = bus.stage_number;
  end
`else
  logic unused_stage_number;
  assign unused_stage_number = ^bus.stage_number;
  assign stage_sel = SW'((STAGE > STAGE_MAX) ? STAGE_MAX : STAGE);
`endif

  // Only the stage matching stage_sel drives each butterfly; a constant select prunes the rest
  always_comb begin
    int unsigned pi, pj, pk;
    pi = 0;
    pj = 0;
    pk = 0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      a_sel[PW'(p)]  = x[0];
      b_sel[PW'(p)]  = x[0];
      w_sel[PW'(p)]  = tw[0];
      wc_sel[PW'(p)] = WOne;
      for (int unsigned s = 0; s < LOG2_SAMPLES; s++) begin
        if (SW'(s) == stage_sel) begin
          pair_of(p, s, SAMPLES, pi, pj, pk);
          a_sel[PW'(p)]  = x[IW'(pi)];
          b_sel[PW'(p)]  = x[IW'(pj)];
          w_sel[PW'(p)]  = tw[IW'(pk)];
          wc_sel[PW'(p)] = wclass_of(pk, SAMPLES);
        end
      end
    end
  end

  for (genvar p = 0; p < PAIRS; p++) begin : g_bf
    fft_butterfly #(
      .HALF_W (HW)
    ) u_bf (
      .a_i      (a_sel[p]),
      .b_i      (b_sel[p]),
      .w_i      (w_sel[p]),
      .wclass_i (wc_sel[p]),
      .sum_o    (bf_sum[p]),
      .diff_o   (bf_diff[p])
    );
  end

  always_comb begin
    int unsigned pi, pj, pk;
    pi      = 0;
    pj      = 0;
    pk      = 0;
    out_d   = out_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      for (int unsigned p = 0; p < PAIRS; p++) begin
        for (int unsigned s = 0; s < LOG2_SAMPLES; s++) begin
          if (SW'(s) == stage_sel) begin
            pair_of(p, s, SAMPLES, pi, pj, pk);
            out_d[IW'(pi)] = bf_sum[PW'(p)];
            out_d[IW'(pj)] = bf_diff[PW'(p)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign bus.out_valid         = valid_q;
  assign bus.display_stream1_1 = out_q;

endmodule

// File: tb/tb_fft_step.sv
// Directed bench for fft_step: N=4 stages 0 and 1, N=8 stage 2, saturation, reset, hold.
module tb_fft_step;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fft_step_if #(.SAMPLES(4), .WIDTH(32)) if_s0 ();
  fft_step_if #(.SAMPLES(4), .WIDTH(32)) if_s1 ();
  fft_step_if #(.SAMPLES(8), .WIDTH(32)) if_n8 ();

  fft_step #(.SAMPLES(4), .WIDTH(32), .STAGE(0)) u_s0 (.clk(clk), .rst(rst), .bus(if_s0.slave));
  fft_step #(.SAMPLES(4), .WIDTH(32), .STAGE(1)) u_s1 (.clk(clk), .rst(rst), .bus(if_s1.slave));
  fft_step #(.SAMPLES(8), .WIDTH(32), .STAGE(2)) u_n8 (.clk(clk), .rst(rst), .bus(if_n8.slave));

  function automatic logic [31:0] pk(input int re, input int im);
    logic [15:0] r;
    logic [15:0] i;
    r = re[15:0];
    i = im[15:0];
    return {i, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4_s0(input int a, input int b, input int c, input int d);
    if_s0.sampleInputs[0] = pk(a, 0);
    if_s0.sampleInputs[1] = pk(b, 0);
    if_s0.sampleInputs[2] = pk(c, 0);
    if_s0.sampleInputs[3] = pk(d, 0);
    if_s0.in_valid = 1'b1;
  endtask

  task automatic init_all();
    rst = 1'b1;
    if_s0.in_valid = 1'b0; if_s0.stage_number = '0;
    if_s1.in_valid = 1'b0; if_s1.stage_number = '0;
    if_n8.in_valid = 1'b0; if_n8.stage_number = '0;
    for (int n = 0; n < 4; n++) begin
      if_s0.sampleInputs[2'(n)] = '0;
      if_s1.sampleInputs[2'(n)] = '0;
    end
    for (int n = 0; n < 8; n++) if_n8.sampleInputs[3'(n)] = '0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    if (if_s0.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid_s0: got %b want 0", if_s0.out_valid);
    end
    n_cmp++;
    if (if_n8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid_n8: got %b want 0", if_n8.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 8; n++) begin
      if (if_n8.display_stream1_1[3'(n)] !== 32'h0) begin
        n_bad++; $display("FAIL reset_word%0d: got %h want 0", n, if_n8.display_stream1_1[3'(n)]);
      end
      n_cmp++;
    end
    rst = 1'b0;
  endtask

  task automatic test_stage0_and_hold();
    logic [31:0] e [4];
    e[0] = pk(250, 0); e[1] = pk(-50, 0); e[2] = pk(450, 0); e[3] = pk(-50, 0);
    drive4_s0(100, 150, 200, 250);
    tick();
    if_s0.in_valid = 1'b0;
    if (if_s0.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stage0_valid: got %b want 1", if_s0.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e[n]) begin
        n_bad++; $display("FAIL stage0_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e[n]);
      end
      n_cmp++;
    end
    drive4_s0(1, 1, 1, 1);
    if_s0.in_valid = 1'b0;
    tick();
    if (if_s0.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_valid: got %b want 0", if_s0.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e[n]) begin
        n_bad++; $display("FAIL hold_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e[n]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_stage1_negj();
    logic [31:0] e [4];
    e[0] = pk(700, 0); e[1] = pk(-50, 50); e[2] = pk(-200, 0); e[3] = pk(-50, -50);
    if_s1.sampleInputs[0] = pk(250, 0);
    if_s1.sampleInputs[1] = pk(-50, 0);
    if_s1.sampleInputs[2] = pk(450, 0);
    if_s1.sampleInputs[3] = pk(-50, 0);
    if_s1.in_valid = 1'b1;
    tick();
    if_s1.in_valid = 1'b0;
    if (if_s1.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL stage1_valid: got %b want 1", if_s1.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 4; n++) begin
      if (if_s1.display_stream1_1[2'(n)] !== e[n]) begin
        n_bad++; $display("FAIL stage1_out%0d: got %h want %h", n, if_s1.display_stream1_1[2'(n)], e[n]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_saturation();
    logic [31:0] e [4];
    e[0] = pk(32767, -32768); e[1] = pk(0, -32767); e[2] = pk(-1, 0); e[3] = pk(-32768, 0);
    if_s0.sampleInputs[0] = pk(32767, -32768);
    if_s0.sampleInputs[1] = pk(32767, -1);
    if_s0.sampleInputs[2] = pk(-32768, 0);
    if_s0.sampleInputs[3] = pk(32767, 0);
    if_s0.in_valid = 1'b1;
    tick();
    if_s0.in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e[n]) begin
        n_bad++; $display("FAIL sat_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e[n]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] e [4];
    e[0] = pk(3, 0); e[1] = pk(-1, 0); e[2] = pk(7, 0); e[3] = pk(-1, 0);
    drive4_s0(100, 150, 200, 250);
    tick();
    drive4_s0(9, 9, 9, 9);
    rst = 1'b1;
    tick();
    if (if_s0.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_valid: got %b want 0", if_s0.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== 32'h0) begin
        n_bad++; $display("FAIL midrst_out%0d: got %h want 0", n, if_s0.display_stream1_1[2'(n)]);
      end
      n_cmp++;
    end
    rst = 1'b0;
    drive4_s0(1, 2, 3, 4);
    tick();
    if_s0.in_valid = 1'b0;
    if (if_s0.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL postrst_valid: got %b want 1", if_s0.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e[n]) begin
        n_bad++; $display("FAIL postrst_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e[n]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1 [4];
    logic [31:0] e2 [4];
    e1[0] = pk(30, 0); e1[1] = pk(-10, 0); e1[2] = pk(70, 0); e1[3] = pk(-10, 0);
    e2[0] = pk(6, 9);  e2[1] = pk(4, 5);   e2[2] = pk(0, 0);  e2[3] = pk(-6, 8);
    drive4_s0(10, 20, 30, 40);
    tick();
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e1[n]) begin
        n_bad++; $display("FAIL b2b_f1_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e1[n]);
      end
      n_cmp++;
    end
    if_s0.sampleInputs[0] = pk(5, 7);
    if_s0.sampleInputs[1] = pk(1, 2);
    if_s0.sampleInputs[2] = pk(-3, 4);
    if_s0.sampleInputs[3] = pk(3, -4);
    tick();
    if_s0.in_valid = 1'b0;
    if (if_s0.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_valid: got %b want 1", if_s0.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e2[n]) begin
        n_bad++; $display("FAIL b2b_f2_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e2[n]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_n8_stage2();
    logic [31:0] e [8];
    e[0] = pk(1000, 0);  e[1] = pk(707, -707); e[2] = pk(0, -1000); e[3] = pk(-707, -707);
    e[4] = pk(-1000, 0); e[5] = pk(-707, 707); e[6] = pk(0, 1000);  e[7] = pk(707, 707);
    for (int n = 0; n < 8; n++) if_n8.sampleInputs[3'(n)] = (n >= 4) ? pk(1000, 0) : 32'h0;
    if_n8.in_valid = 1'b1;
    tick();
    if_n8.in_valid = 1'b0;
    if (if_n8.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL n8_valid: got %b want 1", if_n8.out_valid);
    end
    n_cmp++;
    for (int n = 0; n < 8; n++) begin
      if (if_n8.display_stream1_1[3'(n)] !== e[n]) begin
        n_bad++; $display("FAIL n8_out%0d: got %h want %h", n, if_n8.display_stream1_1[3'(n)], e[n]);
      end
      n_cmp++;
    end
  endtask

`ifdef FFT_STEP_RUNTIME_STAGE_EN
  task automatic test_stage_select();
    logic [31:0] e0 [4];
    logic [31:0] e1 [4];
    e0[0] = pk(250, 0); e0[1] = pk(-50, 0);   e0[2] = pk(450, 0);  e0[3] = pk(-50, 0);
    e1[0] = pk(300, 0); e1[1] = pk(150, -250); e1[2] = pk(-100, 0); e1[3] = pk(150, 250);
    if_s0.stage_number = 1'b0;
    drive4_s0(100, 150, 200, 250);
    tick();
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e0[n]) begin
        n_bad++; $display("FAIL rt_s0_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e0[n]);
      end
      n_cmp++;
    end
    if_s0.stage_number = 1'b1;
    tick();
    if_s0.in_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e1[n]) begin
        n_bad++; $display("FAIL rt_s1_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e1[n]);
      end
      n_cmp++;
    end
    if_s0.stage_number = 1'b0;
    // Out-of-range select on the 8-point instance clamps to its last stage
    if_n8.stage_number = 2'd3;
    test_n8_stage2();
    if_n8.stage_number = 2'd0;
  endtask
`else
  task automatic test_stage_ignored();
    logic [31:0] e [4];
    e[0] = pk(250, 0); e[1] = pk(-50, 0); e[2] = pk(450, 0); e[3] = pk(-50, 0);
    if_s0.stage_number = 1'b1;
    drive4_s0(100, 150, 200, 250);
    tick();
    if_s0.in_valid = 1'b0;
    if_s0.stage_number = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (if_s0.display_stream1_1[2'(n)] !== e[n]) begin
        n_bad++; $display("FAIL fixed_out%0d: got %h want %h", n, if_s0.display_stream1_1[2'(n)], e[n]);
      end
      n_cmp++;
    end
  endtask
`endif

  initial begin
    init_all();
    test_reset();
    test_stage0_and_hold();
    test_stage1_negj();
    test_saturation();
    test_reset_midstream();
    test_back_to_back();
    test_n8_stage2();
`ifdef FFT_STEP_RUNTIME_STAGE_EN
    test_stage_select();
`else
    test_stage_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
